// File: rtl/key_ctrl_pkg.sv
// key_ctrl shared definitions
// field/state encodings and counter width helper
package key_ctrl_pkg;

    typedef enum logic [1:0] {
        FIELD_RUN  = 2'd0,
        FIELD_HOUR = 2'd1,
        FIELD_MIN  = 2'd2,
        FIELD_SEC  = 2'd3
    } field_e;

    // bits needed to hold 0..v inclusive
    function automatic int cnt_w(input int v);
        return $clog2(v) + 1;
    endfunction

endpackage

// File: rtl/key_ctrl_if.sv
// key panel bus between the key debouncers/timekeeper and key_ctrl
// master drives presses and raw levels, slave drives strobes
interface key_ctrl_if;
    logic       scan_tick;
    logic       mode_press;
    logic       inc_press;
    logic       dec_press;
    logic       inc_raw;
    logic       dec_raw;
    logic [1:0] field;
    logic       edit_active;
    logic       adj_up;
    logic       adj_down;
    logic       field_blank;

    modport master (
        output mode_press, inc_press, dec_press, inc_raw, dec_raw,
        input  scan_tick, field, edit_active, adj_up, adj_down,
        input  field_blank
    );

    modport slave (
        input  mode_press, inc_press, dec_press, inc_raw, dec_raw,
        output scan_tick, field, edit_active, adj_up, adj_down,
        output field_blank
    );
endinterface

// File: rtl/key_repeat.sv
// hold-to-repeat generator for one key
// fire is combinational on the qualifying tick; the top registers it
module key_repeat
    import key_ctrl_pkg::*;
#(
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic press,
    input  logic raw,
    input  logic other_raw,
    input  logic enable,
    output logic fire
);
    localparam int HW = cnt_w(REPEAT_DELAY);
    localparam int RW = cnt_w(REPEAT_RATE);
    localparam logic [HW-1:0] DLY = HW'(REPEAT_DELAY);

    logic [HW-1:0] hold;
    logic [RW-1:0] rate;
    logic          held;
    logic          at_dly;
    logic          rate_hit;

    assign held     = !raw && enable;
    assign at_dly   = hold == DLY;
    assign rate_hit = rate == RW'(REPEAT_RATE - 1);
    assign fire     = tick && !press && held && other_raw &&
                      ((hold == DLY - HW'(1)) || (at_dly && rate_hit));

    // hold counter saturates at the delay; rate counter paces later repeats
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold <= '0;
            rate <= '0;
        end else if (press) begin
            hold <= '0;
            rate <= '0;
        end else if (tick) begin
            if (!held) begin
                hold <= '0;
                rate <= '0;
            end else if (!at_dly) begin
                hold <= hold + HW'(1);
                rate <= '0;
            end else begin
                rate <= rate_hit ? '0 : rate + RW'(1);
            end
        end
    end
endmodule

// File: rtl/key_ctrl.sv
// key panel controller: scan tick, time-set FSM, adjust strobes,
// idle timeout and field blink
module key_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int TICK_DIV      = 200000,
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_RATE   = 10,
    parameter int TIMEOUT_TICKS = 500,
    parameter int BLINK_TICKS   = 25
) (
    input logic       clock,
    input logic       reset,
    key_ctrl_if.slave kif
);
    localparam int DW = cnt_w(TICK_DIV);
    localparam int TW = cnt_w(TIMEOUT_TICKS);
    localparam int BW = cnt_w(BLINK_TICKS);

    logic [DW-1:0] div;
    logic [TW-1:0] idle;
    logic [BW-1:0] blink;
    field_e        state;
    field_e        state_nx;
    logic          blank;
    logic          up_q;
    logic          dn_q;
    logic          tick;
    logic          set;
    logic          acc_inc;
    logic          acc_dec;
    logic          rep_inc;
    logic          rep_dec;
    logic          adj_ev;
    logic          moved;
    logic          timeout;

    assign tick    = div == DW'(TICK_DIV - 1);
    assign set     = state != FIELD_RUN;
    assign acc_inc = set && kif.inc_press && !kif.dec_press && !kif.mode_press;
    assign acc_dec = set && kif.dec_press && !kif.inc_press && !kif.mode_press;
    assign adj_ev  = acc_inc || acc_dec || rep_inc || rep_dec;
    assign timeout = set && tick && !adj_ev && !kif.mode_press &&
                     (idle == TW'(TIMEOUT_TICKS - 1));
    assign moved   = state_nx != state;

    key_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_rep_inc (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick),
        .press    (kif.inc_press),
        .raw      (kif.inc_raw),
        .other_raw(kif.dec_raw),
        .enable   (set),
        .fire     (rep_inc)
    );

    key_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_rep_dec (
        .clock    (clock),
        .reset    (reset),
        .tick     (tick),
        .press    (kif.dec_press),
        .raw      (kif.dec_raw),
        .other_raw(kif.inc_raw),
        .enable   (set),
        .fire     (rep_dec)
    );

    // scan tick divider, wraps at TICK_DIV-1
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) div <= '0;
        else        div <= tick ? '0 : div + DW'(1);
    end

    // mode press advances; idle timeout falls back to run
    always_comb begin
        state_nx = state;
        unique case (1'b1)
            kif.mode_press: state_nx = field_e'(state + 2'd1);
            timeout:        state_nx = FIELD_RUN;
            default:        ;
        endcase
    end

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= FIELD_RUN;
        else        state <= state_nx;
    end

    // idle counter, restarted by any activity
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                       idle <= '0;
        else if (!set || moved || adj_ev) idle <= '0;
        else if (tick)                    idle <= idle + TW'(1);
    end

    // blink phase, forced visible on entry and on every adjust
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink <= '0;
            blank <= 1'b0;
        end else if (!set || moved || adj_ev) begin
            blink <= '0;
            blank <= 1'b0;
        end else if (tick) begin
            if (blink == BW'(BLINK_TICKS - 1)) begin
                blink <= '0;
                blank <= !blank;
            end else begin
                blink <= blink + BW'(1);
            end
        end
    end

    // registered adjust strobes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            up_q <= 1'b0;
            dn_q <= 1'b0;
        end else begin
            up_q <= acc_inc || rep_inc;
            dn_q <= acc_dec || rep_dec;
        end
    end

    assign kif.scan_tick   = tick;
    assign kif.field       = state;
    assign kif.edit_active = set;
    assign kif.adj_up      = up_q;
    assign kif.adj_down    = dn_q;
    assign kif.field_blank = blank;
endmodule

// File: tb/tb_key_ctrl.sv
// key_ctrl testbench: vector table, hand sequences and random
// stimulus against a behavioural model
module tb_key_ctrl;
    localparam int TD = 4;
    localparam int RD = 5;
    localparam int RR = 2;
    localparam int TO = 20;
    localparam int BT = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    key_ctrl_if kif();

    key_ctrl #(
        .TICK_DIV     (TD),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR),
        .TIMEOUT_TICKS(TO),
        .BLINK_TICKS  (BT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .kif  (kif)
    );

    int n_chk = 0;
    int n_fail = 0;

    // model: ticks from a cycle count, unbounded hold counts, modulo repeat rule
    int m_cyc;
    int m_state;
    int m_hold[2];
    int m_idle;
    int m_bcnt;
    bit m_blank;
    bit m_up;
    bit m_dn;

    typedef struct {
        bit m;
        bit i;
        bit d;
        int f;
        bit up;
        bit dn;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_cyc = 0;
        m_state = 0;
        m_hold[0] = 0;
        m_hold[1] = 0;
        m_idle = 0;
        m_bcnt = 0;
        m_blank = 0;
        m_up = 0;
        m_dn = 0;
    endfunction

    function automatic bit rep_of(input int k, input bit pr, input bit held,
                                  input bit oth, input bit tk, input bit set);
        bit f = 0;
        if (pr) m_hold[k] = 0;
        else if (tk) begin
            if (held && set) begin
                m_hold[k]++;
                f = !oth && m_hold[k] >= RD && ((m_hold[k] - RD) % RR) == 0;
            end else begin
                m_hold[k] = 0;
            end
        end
        return f;
    endfunction

    function automatic void model_step();
        bit tk = (m_cyc % TD) == TD - 1;
        bit set = m_state != 0;
        bit md = kif.mode_press;
        bit pi = kif.inc_press;
        bit pd = kif.dec_press;
        bit hi = !kif.inc_raw;
        bit hd = !kif.dec_raw;
        bit ai = set && pi && !pd && !md;
        bit ad = set && pd && !pi && !md;
        bit ri;
        bit rd;
        bit ev;
        int ns;
        ri = rep_of(0, pi, hi, hd, tk, set);
        rd = rep_of(1, pd, hd, hi, tk, set);
        ev = ai || ad || ri || rd;
        ns = m_state;
        if (md) ns = (m_state + 1) % 4;
        else if (set && tk && !ev && m_idle + 1 >= TO) ns = 0;
        if (!set || ns != m_state || ev) begin
            m_idle = 0;
            m_bcnt = 0;
            m_blank = 0;
        end else if (tk) begin
            m_idle++;
            m_bcnt++;
            if (m_bcnt == BT) begin
                m_bcnt = 0;
                m_blank = !m_blank;
            end
        end
        m_up = ai || ri;
        m_dn = ad || rd;
        m_state = ns;
        m_cyc++;
    endfunction

    function automatic int exp_vec();
        int tk = ((m_cyc % TD) == TD - 1) ? 1 : 0;
        int ed = (m_state != 0) ? 1 : 0;
        return (tk << 6) | (m_state << 4) | (ed << 3) |
               (int'(m_up) << 2) | (int'(m_dn) << 1) | int'(m_blank);
    endfunction

    function automatic int outs();
        return int'({kif.scan_tick, kif.field, kif.edit_active,
                     kif.adj_up, kif.adj_down, kif.field_blank});
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check("model", outs(), exp_vec());
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        check("rst_async", outs(), 0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_hold", outs(), 0);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic to_tick();
        int n = 0;
        while (!kif.scan_tick && n < 2 * TD) begin
            cycle();
            n++;
        end
        if (!kif.scan_tick) begin
            n_chk++;
            n_fail++;
            $display("FAIL tick_wait: no scan_tick within %0d cycles", 2 * TD);
        end
    endtask

    task automatic press(input bit m, input bit i, input bit d);
        to_tick();
        kif.mode_press = m;
        kif.inc_press = i;
        kif.dec_press = d;
        cycle();
        kif.mode_press = 0;
        kif.inc_press = 0;
        kif.dec_press = 0;
    endtask

    task automatic rand_phase(input int n, input int pmax, input int rmax);
        for (int c = 0; c < n; c++) begin
            kif.mode_press = ($urandom_range(0, 149) == 0);
            kif.inc_press = ($urandom_range(0, pmax) == 0);
            kif.dec_press = ($urandom_range(0, pmax) == 0);
            if ($urandom_range(0, rmax) == 0) kif.inc_raw = !kif.inc_raw;
            if ($urandom_range(0, rmax) == 0) kif.dec_raw = !kif.dec_raw;
            cycle();
        end
        kif.mode_press = 0;
        kif.inc_press = 0;
        kif.dec_press = 0;
        kif.inc_raw = 1;
        kif.dec_raw = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt;
        int guard;
        int cnt;
        int reps[$];
        int exp_rep[4];
        bit tk;

        kif.mode_press = 0;
        kif.inc_press = 0;
        kif.dec_press = 0;
        kif.inc_raw = 1;
        kif.dec_raw = 1;
        model_reset();
        #1;
        do_reset();

        // reset and tick spacing
        for (int k = 1; k <= 40; k++) begin
            cycle();
            check($sformatf("tick_c%0d", k), kif.scan_tick, (k % TD) == TD - 1);
            check($sformatf("quiet_c%0d", k), outs() & 63, 0);
        end

        // mode cycling and press priority
        tbl[0]  = '{0, 1, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 1, 0, 0};
        tbl[2]  = '{0, 1, 0, 1, 1, 0};
        tbl[3]  = '{0, 0, 1, 1, 0, 1};
        tbl[4]  = '{0, 1, 1, 1, 0, 0};
        tbl[5]  = '{1, 0, 0, 2, 0, 0};
        tbl[6]  = '{0, 1, 0, 2, 1, 0};
        tbl[7]  = '{0, 1, 1, 2, 0, 0};
        tbl[8]  = '{1, 1, 0, 3, 0, 0};
        tbl[9]  = '{0, 0, 1, 3, 0, 1};
        tbl[10] = '{1, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 1, 0, 0, 0};
        foreach (tbl[k]) begin
            press(tbl[k].m, tbl[k].i, tbl[k].d);
            check($sformatf("vec%0d_field", k), kif.field, tbl[k].f);
            check($sformatf("vec%0d_edit", k), kif.edit_active, tbl[k].f != 0);
            check($sformatf("vec%0d_up", k), kif.adj_up, tbl[k].up);
            check($sformatf("vec%0d_dn", k), kif.adj_down, tbl[k].dn);
        end

        // auto-repeat in set hour
        press(1, 0, 0);
        check("rep_field", kif.field, 1);
        to_tick();
        kif.inc_raw = 0;
        kif.inc_press = 1;
        cycle();
        kif.inc_press = 0;
        check("rep_press", kif.adj_up, 1);
        nt = 0;
        guard = 0;
        while (nt < 24 && guard < 200) begin
            tk = kif.scan_tick;
            cycle();
            guard++;
            if (tk) begin
                nt++;
                if (nt == 12) kif.inc_raw = 1;
            end
            if (kif.adj_up) reps.push_back(nt);
        end
        kif.inc_raw = 1;
        check("rep_ticks_seen", nt, 24);
        exp_rep = '{5, 7, 9, 11};
        check("rep_count", reps.size(), 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("rep%0d_tick", k),
                  (k < reps.size()) ? reps[k] : -1, exp_rep[k]);

        // idle timeout and blink in set second
        press(1, 0, 0);
        press(1, 0, 0);
        check("to_field", kif.field, 3);
        check("to_blank0", kif.field_blank, 0);
        nt = 0;
        guard = 0;
        while (nt < TO && guard < 200) begin
            tk = kif.scan_tick;
            cycle();
            guard++;
            if (tk) begin
                nt++;
                check($sformatf("blink_t%0d", nt), kif.field_blank,
                      (nt < TO) ? (nt / BT) % 2 : 0);
                check($sformatf("to_field_t%0d", nt), kif.field,
                      (nt < TO) ? 3 : 0);
            end
        end
        check("to_ticks_seen", nt, TO);
        check("to_edit", kif.edit_active, 0);

        // reset mid-edit with dec held
        press(1, 0, 0);
        press(1, 0, 0);
        check("mid_field", kif.field, 2);
        kif.dec_raw = 0;
        repeat (3 * TD) cycle();
        do_reset();
        check("mid_rst_field", kif.field, 0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (kif.adj_down) cnt++;
        end
        check("mid_no_down", cnt, 0);
        kif.dec_raw = 1;

        // random traffic against the model
        rand_phase(3000, 30, 40);
        rand_phase(3000, 250, 60);
        rand_phase(1000, 8, 20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
